// File: rtl/tlb_op_ctrl.sv
// TLB maintenance controller: sequences TLBR/TLBWI/TLBWR/TLBP against the TLB array,
// owns the CP0 Random register and produces one-cycle CP0 writeback pulses.
module tlb_op_ctrl #(
  parameter int ENTRY_NUM = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  input  logic [31:0] cp0_pagemask,
  input  logic [4:0]  wired,
  input  logic        wired_we,
  output logic [4:0]  random,
  output logic        wtlb,
  output logic [4:0]  tlb_addr,
  output logic [89:0] tlb_wdata,
  input  logic [89:0] tlbr_result,
  input  logic [31:0] tlbp_result,
  output logic        probe_active,
  output logic [31:0] probe_va,
  output logic        wb_valid,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_index,
  output logic [31:0] wb_entryhi,
  output logic [31:0] wb_entrylo0,
  output logic [31:0] wb_entrylo1,
  output logic [31:0] wb_pagemask,
  output logic [2:0]  fsm_state
);

  localparam logic [4:0] RAND_MAX = 5'(ENTRY_NUM - 1);
  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_PROBE, S_PROBE_WAIT, S_DONE
  } state_t;

  state_t      state;
  logic        accept;
  logic [89:0] wdata_next;
  logic        unused_bits;

  // Handshake: a request transfers on a cycle where op_valid and op_ready are both high;
  // op_ready is combinational so flush blocks acceptance in the same cycle.
  assign op_ready  = rst_n && (state == S_IDLE) && !flush;
  assign accept    = op_valid && op_ready;
  assign fsm_state = state;

  assign wdata_next = {cp0_pagemask[24:13], cp0_entryhi[31:13], cp0_entryhi[7:0],
                       cp0_entrylo0[0] & cp0_entrylo1[0],
                       cp0_entrylo0[25:1], cp0_entrylo1[25:1]};

  assign unused_bits = ^{cp0_index[31:5], cp0_entryhi[12:8], cp0_entrylo0[31:26],
                         cp0_entrylo1[31:26], cp0_pagemask[31:25], cp0_pagemask[12:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      random       <= RAND_MAX;
      busy         <= 1'b0;
      wtlb         <= 1'b0;
      tlb_addr     <= '0;
      tlb_wdata    <= '0;
      probe_active <= 1'b0;
      probe_va     <= '0;
      wb_valid     <= 1'b0;
      wb_sel       <= '0;
      wb_index     <= '0;
      wb_entryhi   <= '0;
      wb_entrylo0  <= '0;
      wb_entrylo1  <= '0;
      wb_pagemask  <= '0;
    end else begin
      // Random counts down to Wired and wraps back to the top entry.
      if (wired_we || (random == wired)) random <= RAND_MAX;
      else                               random <= random - 5'd1;

      wtlb     <= 1'b0;
      wb_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            tlb_addr <= (op_code == OP_TLBWR) ? random : cp0_index[4:0];
            case (op_code)
              OP_TLBR: state <= S_READ;
              OP_TLBWI, OP_TLBWR: begin
                state     <= S_WRITE;
                wtlb      <= 1'b1;
                tlb_wdata <= wdata_next;
              end
              OP_TLBP: begin
                state        <= S_PROBE;
                probe_active <= 1'b1;
                probe_va     <= {cp0_entryhi[31:13], 13'b0};
              end
            endcase
          end
        end
        S_WRITE: state <= S_DONE;
        S_READ: begin
          wb_valid    <= 1'b1;
          wb_sel      <= 2'b00;
          wb_entryhi  <= {tlbr_result[77:59], 5'b0, tlbr_result[58:51]};
          wb_entrylo0 <= {6'b0, tlbr_result[49:25], tlbr_result[50]};
          wb_entrylo1 <= {6'b0, tlbr_result[24:0], tlbr_result[50]};
          wb_pagemask <= {7'b0, tlbr_result[89:78], 13'b0};
          state       <= S_DONE;
        end
        S_PROBE: state <= S_PROBE_WAIT;
        S_PROBE_WAIT: begin
          probe_active <= 1'b0;
          wb_valid     <= 1'b1;
          wb_sel       <= 2'b11;
          wb_index     <= tlbp_result;
          state        <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          probe_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic against a latency/field-mapping reference model.
module tb_tlb_op_ctrl;

  localparam int W = 95;
  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_WI = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_P  = 2'b11;

  logic        clk, rst_n, op_valid, flush, wired_we;
  logic [1:0]  op_code;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_pagemask;
  logic [4:0]  wired;
  logic [89:0] tlbr_result;
  logic [31:0] tlbp_result;
  logic        op_ready, busy, wtlb, probe_active, wb_valid;
  logic [4:0]  random, tlb_addr;
  logic [89:0] tlb_wdata;
  logic [31:0] probe_va, wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1, wb_pagemask;
  logic [1:0]  wb_sel;
  logic [2:0]  fsm_state;

  tlb_op_ctrl #(.ENTRY_NUM(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .flush(flush),
    .op_ready(op_ready), .busy(busy),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
    .cp0_entrylo1(cp0_entrylo1), .cp0_pagemask(cp0_pagemask),
    .wired(wired), .wired_we(wired_we), .random(random),
    .wtlb(wtlb), .tlb_addr(tlb_addr), .tlb_wdata(tlb_wdata),
    .tlbr_result(tlbr_result), .tlbp_result(tlbp_result),
    .probe_active(probe_active), .probe_va(probe_va),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_index(wb_index), .wb_entryhi(wb_entryhi),
    .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1), .wb_pagemask(wb_pagemask),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] idx, hi, lo0, lo1, pm;
  } wb_t;

  logic [W-1:0] exp_q[$];
  wb_t          wb_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           ref_rand = 31;
  bit           m_busy = 1'b0;
  int           m_age = 0;
  logic [1:0]   m_op = 2'b00;
  logic [4:0]   m_addr = '0;
  logic [31:0]  m_va = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int op_len(input logic [1:0] op);
    return (op == OP_P) ? 4 : 3;
  endfunction

  function automatic logic [89:0] make_entry(input logic [31:0] hi, lo0, lo1, pm);
    return {pm[24:13], hi[31:13], hi[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
  endfunction

  function automatic wb_t read_wb(input logic [89:0] e);
    wb_t w;
    w.sel = 2'b00;
    w.idx = '0;
    w.hi  = {e[77:59], 5'b0, e[58:51]};
    w.lo0 = {6'b0, e[49:25], e[50]};
    w.lo1 = {6'b0, e[24:0], e[50]};
    w.pm  = {7'b0, e[89:78], 13'b0};
    return w;
  endfunction

  task automatic check_outputs();
    logic [9:0]   act, exp;
    bit           e_wtlb, e_probe, e_wbv, e_ready;
    logic [W-1:0] ew;
    wb_t          w;
    e_wtlb  = m_busy && (m_op == OP_WI || m_op == OP_WR) && m_age == 1;
    e_probe = m_busy && m_op == OP_P && m_age <= 2;
    e_wbv   = m_busy && ((m_op == OP_R && m_age == 2) || (m_op == OP_P && m_age == 3));
    e_ready = rst_n && !m_busy && !flush;
    act = {busy, wtlb, probe_active, wb_valid, op_ready, random};
    exp = {m_busy, e_wtlb, e_probe, e_wbv, e_ready, 5'(ref_rand)};
    check("ctl", 128'(act), 128'(exp));
    if (e_wtlb) begin
      check("wq_size", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        ew = exp_q.pop_front();
        check("wtlb_data", 128'({tlb_addr, tlb_wdata}), 128'(ew));
      end
    end
    if (m_busy && m_op == OP_R && m_age == 1) check("rd_addr", 128'(tlb_addr), 128'(m_addr));
    if (e_probe) check("probe_va", 128'(probe_va), 128'(m_va));
    if (e_wbv) begin
      check("wbq_size", 128'(wb_q.size() != 0), 128'(1));
      if (wb_q.size() != 0) begin
        w = wb_q.pop_front();
        check("wb_sel", 128'(wb_sel), 128'(w.sel));
        if (w.sel == 2'b11) begin
          check("wb_index", 128'(wb_index), 128'(w.idx));
        end else begin
          check("wb_hi", 128'(wb_entryhi), 128'(w.hi));
          check("wb_lo0", 128'(wb_entrylo0), 128'(w.lo0));
          check("wb_lo1", 128'(wb_entrylo1), 128'(w.lo1));
          check("wb_pm", 128'(wb_pagemask), 128'(w.pm));
        end
      end
    end
  endtask

  // Advance the model with the inputs present before the edge, clock, then compare.
  task automatic tick();
    wb_t w;
    if (!rst_n) begin
      m_busy = 1'b0;
      exp_q.delete();
      wb_q.delete();
      ref_rand = 31;
    end else begin
      if (m_busy) begin
        if (m_op == OP_R && m_age == 1) wb_q.push_back(read_wb(tlbr_result));
        if (m_op == OP_P && m_age == 2) begin
          w = '{sel: 2'b11, idx: tlbp_result, hi: '0, lo0: '0, lo1: '0, pm: '0};
          wb_q.push_back(w);
        end
        m_age++;
        if (m_age >= op_len(m_op)) m_busy = 1'b0;
      end else if (op_valid && !flush) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_op   = op_code;
        m_addr = (op_code == OP_WR) ? 5'(ref_rand) : cp0_index[4:0];
        m_va   = {cp0_entryhi[31:13], 13'b0};
        if (op_code == OP_WI || op_code == OP_WR)
          exp_q.push_back({m_addr, make_entry(cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_pagemask)});
      end
      ref_rand = (wired_we || ref_rand == int'(wired)) ? 31 : ((ref_rand - 1) & 31);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] idx, hi, lo0, lo1, pm;
    logic [89:0] tlbr;
    logic [31:0] tlbp;
    logic [4:0]  e_addr;
    logic [89:0] e_wdata;
    logic [31:0] e_va, e_hi, e_lo0, e_lo1, e_pm, e_idx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [95:0] r96;
    int          seq[4];

    vecs[0] = '{default: '0, op: OP_WI, idx: 32'd5, hi: 32'h00402012, lo0: 32'h00001017,
                lo1: 32'h00001057, e_addr: 5'd5,
                e_wdata: {12'h000, 19'h00201, 8'h12, 1'b1, 25'h000080B, 25'h000082B}};
    vecs[1] = '{default: '0, op: OP_WI, idx: 32'd31, hi: 32'hFFFFFFFF, lo0: 32'h03FFFFFE,
                lo1: 32'h03FFFFFF, pm: 32'h01FFE000, e_addr: 5'd31,
                e_wdata: {12'hFFF, 19'h7FFFF, 8'hFF, 1'b0, 25'h1FFFFFF, 25'h1FFFFFF}};
    vecs[2] = '{default: '0, op: OP_R, idx: 32'd7,
                tlbr: {12'h0FF, 19'h12345, 8'hA5, 1'b1, 25'h1ABCDEF, 25'h0123457},
                e_addr: 5'd7, e_hi: 32'h2468A0A5, e_lo0: 32'h03579BDF,
                e_lo1: 32'h002468AF, e_pm: 32'h001FE000};
    vecs[3] = '{default: '0, op: OP_R, idx: 32'd2,
                tlbr: {12'hFFF, 19'h7FFFF, 8'hFF, 1'b0, 25'h1FFFFFF, 25'h1FFFFFF},
                e_addr: 5'd2, e_hi: 32'hFFFFE0FF, e_lo0: 32'h03FFFFFE,
                e_lo1: 32'h03FFFFFE, e_pm: 32'h01FFE000};
    vecs[4] = '{default: '0, op: OP_P, hi: 32'h80004000, tlbp: 32'h00000003,
                e_va: 32'h80004000, e_idx: 32'h00000003};
    vecs[5] = '{default: '0, op: OP_P, hi: 32'h12345FFF, tlbp: 32'h80000000,
                e_va: 32'h12344000, e_idx: 32'h80000000};

    rst_n = 1'b0; op_valid = 1'b0; op_code = OP_R; flush = 1'b0; wired_we = 1'b0;
    wired = 5'd28; cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0;
    cp0_entrylo1 = '0; cp0_pagemask = '0; tlbr_result = '0; tlbp_result = '0;

    // Reset state
    tick();
    tick();
    check("rst_random", 128'(random), 128'(31));
    check("rst_ready", 128'(op_ready), 128'(0));
    check("rst_addr", 128'(tlb_addr), 128'(0));
    check("rst_wdata", 128'(tlb_wdata), 128'(0));
    check("rst_wb", 128'({wb_sel, wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1}), 128'(0));
    check("rst_wb_pm", 128'(wb_pagemask), 128'(0));

    // Random sequence with Wired=28
    rst_n = 1'b1;
    seq = '{30, 29, 28, 31};
    foreach (seq[i]) begin
      tick();
      check("rand_seq", 128'(random), 128'(seq[i]));
    end
    tick();
    tick();
    check("rand_29", 128'(random), 128'(29));
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    check("rand_wired_we", 128'(random), 128'(31));
    tick();
    check("rand_30", 128'(random), 128'(30));
    op_valid = 1'b1; op_code = OP_WR; cp0_index = 32'd3;
    cp0_entryhi = 32'hABCDE0FF; cp0_entrylo0 = 32'h00000F03; cp0_entrylo1 = 32'h00000A01;
    tick();
    op_valid = 1'b0;
    check("tlbwr_wtlb", 128'(wtlb), 128'(1));
    check("tlbwr_addr", 128'(tlb_addr), 128'(30));
    tick();
    tick();

    // Wired=31 pins Random at 31
    wired = 5'd31; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rand_pin31", 128'(random), 128'(31));
    end
    wired = 5'd8;

    // Table-driven operations
    for (int i = 0; i < 6; i++) begin
      cp0_index = vecs[i].idx; cp0_entryhi = vecs[i].hi; cp0_entrylo0 = vecs[i].lo0;
      cp0_entrylo1 = vecs[i].lo1; cp0_pagemask = vecs[i].pm;
      tlbr_result = vecs[i].tlbr; tlbp_result = vecs[i].tlbp;
      op_code = vecs[i].op; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      if (vecs[i].op == OP_WI) begin
        check("vec_wtlb", 128'(wtlb), 128'(1));
        check("vec_addr", 128'(tlb_addr), 128'(vecs[i].e_addr));
        check("vec_wdata", 128'(tlb_wdata), 128'(vecs[i].e_wdata));
      end
      if (vecs[i].op == OP_R) check("vec_raddr", 128'(tlb_addr), 128'(vecs[i].e_addr));
      if (vecs[i].op == OP_P) check("vec_va1", 128'(probe_va), 128'(vecs[i].e_va));
      tick();
      if (vecs[i].op == OP_R) begin
        check("vec_rvalid", 128'(wb_valid), 128'(1));
        check("vec_rsel", 128'(wb_sel), 128'(0));
        check("vec_rhi", 128'(wb_entryhi), 128'(vecs[i].e_hi));
        check("vec_rlo0", 128'(wb_entrylo0), 128'(vecs[i].e_lo0));
        check("vec_rlo1", 128'(wb_entrylo1), 128'(vecs[i].e_lo1));
        check("vec_rpm", 128'(wb_pagemask), 128'(vecs[i].e_pm));
      end
      if (vecs[i].op == OP_P) begin
        check("vec_va2", 128'({probe_active, probe_va}), 128'({1'b1, vecs[i].e_va}));
        tick();
        check("vec_pvalid", 128'(wb_valid), 128'(1));
        check("vec_psel", 128'(wb_sel), 128'(3));
        check("vec_pidx", 128'(wb_index), 128'(vecs[i].e_idx));
      end
      tick();
      check("vec_idle", 128'(busy), 128'(0));
    end

    // flush in IDLE blocks acceptance; flush during WRITE does not cancel it
    flush = 1'b1; op_valid = 1'b1; op_code = OP_WI; cp0_index = 32'd9;
    #1;
    check("flush_ready", 128'(op_ready), 128'(0));
    tick();
    check("flush_noacc", 128'(busy), 128'(0));
    flush = 1'b0;
    tick();
    op_valid = 1'b0; flush = 1'b1;
    check("flush_wtlb", 128'(wtlb), 128'(1));
    tick();
    tick();
    flush = 1'b0;

    // Reset during PROBE_WAIT abandons the probe
    op_valid = 1'b1; op_code = OP_P; cp0_entryhi = 32'h7FFFE000; tlbp_result = 32'h5;
    tick();
    op_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rstpw_busy", 128'({busy, probe_active, wb_valid}), 128'(0));
    rst_n = 1'b1;
    tick();
    check("rstpw_wbv", 128'(wb_valid), 128'(0));
    tick();
    check("rstpw_wbv2", 128'(wb_valid), 128'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      op_valid     = $urandom_range(0, 1);
      op_code      = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 3) == 0);
      cp0_index    = $urandom;
      cp0_entryhi  = $urandom;
      cp0_entrylo0 = $urandom;
      cp0_entrylo1 = $urandom;
      cp0_pagemask = $urandom;
      if ($urandom_range(0, 15) == 0) wired = 5'($urandom_range(0, 31));
      wired_we     = ($urandom_range(0, 11) == 0);
      r96          = {$urandom, $urandom, $urandom};
      tlbr_result  = r96[89:0];
      tlbp_result  = $urandom;
      tick();
    end

    rst_n = 1'b1; op_valid = 1'b0; flush = 1'b0; wired_we = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("drain_w", 128'(exp_q.size()), 128'(0));
    check("drain_wb", 128'(wb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
